// File: rtl/speck_round_key_sequencer_if.sv
// Handshake bundle between the round key sequencer and the SPECK key
// schedule block. The sequencer drives the running key, the iteration
// index and the start pulse. The key schedule block returns a level done
// flag and the next running key.
interface speck_round_key_sequencer_if #(
    parameter int KEY_SIZE   = 128,
    parameter int BLOCK_SIZE = 64
) ();
    logic [KEY_SIZE-1:0]   ks_key;
    logic [BLOCK_SIZE-1:0] ks_round_ctr;
    logic                  ks_start;
    logic                  ks_done;
    logic [KEY_SIZE-1:0]   ks_out_key;

    // Sequencer side
    modport master (
        output ks_key,
        output ks_round_ctr,
        output ks_start,
        input  ks_done,
        input  ks_out_key
    );

    // Key schedule block side
    modport slave (
        input  ks_key,
        input  ks_round_ctr,
        input  ks_start,
        output ks_done,
        output ks_out_key
    );
endinterface

// File: rtl/speck_round_key_sequencer.sv
// SPECK round key sequencer.
// Drives the external key schedule block once per round, starting from a
// master key. Each round key is the low word of the running key, and every
// round key is kept in a ROUNDS-deep buffer. The cipher round engine reads
// that buffer through a registered random-access port. A watchdog aborts
// the expansion when the key schedule block does not answer in time.
module speck_round_key_sequencer #(
    parameter int KEY_SIZE   = 128,
    parameter int BLOCK_SIZE = 64,
    parameter int ROUNDS     = 32,
    parameter int ADDR_W     = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_SIZE-1:0]   key_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  keys_valid,
    output logic                  error,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [BLOCK_SIZE-1:0] rd_data,
    speck_round_key_sequencer_if.master ks
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_STORE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    // Watchdog counter is wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1
    localparam int                WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ITER = ADDR_W'(ROUNDS - 2);
    localparam logic [ADDR_W-1:0] ITER_ONE  = ADDR_W'(1);
    localparam int                CTR_PAD   = BLOCK_SIZE - ADDR_W;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            state_r;
    logic [ADDR_W-1:0]     iter_r;
    logic [WD_W-1:0]       wd_cnt_r;
    logic                  ks_done_q_r;
    logic [KEY_SIZE-1:0]   ks_key_r;
    logic [BLOCK_SIZE-1:0] ks_round_ctr_r;
    logic                  ks_start_r;
    logic                  busy_r;
    logic                  keys_valid_r;
    logic                  error_r;
    logic [BLOCK_SIZE-1:0] rd_data_r;

    // Round key storage; not reset, since keys_valid_r gates every read
    logic [BLOCK_SIZE-1:0] key_buf_r [ROUNDS];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2:0]            state_nxt_s;
    logic                  start_ok_s;
    logic                  ks_event_s;
    logic                  wd_expired_s;
    logic                  last_iter_s;
    logic [ADDR_W-1:0]     iter_inc_s;
    logic                  buf_we_s;
    logic [ADDR_W-1:0]     buf_waddr_s;
    logic [BLOCK_SIZE-1:0] buf_wdata_s;
    logic                  rd_in_range_s;

    // A start request counts only when the sequencer is not busy
    assign start_ok_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    // Only a rising edge of ks_done counts. A done level left over from the previous round is ignored.
    assign ks_event_s   = ks.ks_done & ~ks_done_q_r;
    assign wd_expired_s = (wd_cnt_r == WD_LAST);
    assign last_iter_s  = (iter_r == LAST_ITER);
    assign iter_inc_s   = iter_r + ITER_ONE;

    // Addresses past the last stored key read as zero. The range check is needed only when the address space is larger than the buffer.
    generate
        if (ROUNDS < (2 ** ADDR_W)) begin : g_addr_check
            assign rd_in_range_s = ({1'b0, rd_addr} < (ADDR_W + 1)'(ROUNDS));
        end else begin : g_addr_full
            assign rd_in_range_s = 1'b1;
        end
    endgenerate

    // Outputs come straight from registers
    assign busy            = busy_r;
    assign keys_valid      = keys_valid_r;
    assign error           = error_r;
    assign rd_data         = rd_data_r;
    assign ks.ks_key       = ks_key_r;
    assign ks.ks_round_ctr = ks_round_ctr_r;
    assign ks.ks_start     = ks_start_r;

    // Next-state selection for the expansion sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD:  state_nxt_s = ST_ISSUE;
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (ks_event_s) begin
                    state_nxt_s = ST_STORE;
                end else if (wd_expired_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_STORE: begin
                if (last_iter_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ERROR: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Buffer write port: master key low word in LOAD, each new round key in STORE
    always_comb begin
        buf_we_s    = 1'b0;
        buf_waddr_s = {ADDR_W{1'b0}};
        buf_wdata_s = {BLOCK_SIZE{1'b0}};
        if (!rst && (state_r == ST_LOAD)) begin
            buf_we_s    = 1'b1;
            buf_waddr_s = {ADDR_W{1'b0}};
            buf_wdata_s = ks_key_r[BLOCK_SIZE-1:0];
        end else if (!rst && (state_r == ST_STORE)) begin
            buf_we_s    = 1'b1;
            buf_waddr_s = iter_inc_s;
            buf_wdata_s = ks.ks_out_key[BLOCK_SIZE-1:0];
        end else begin
            buf_we_s    = 1'b0;
        end
    end

    // Control registers, the key schedule handshake and the watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            iter_r         <= {ADDR_W{1'b0}};
            wd_cnt_r       <= {WD_W{1'b0}};
            ks_done_q_r    <= 1'b0;
            ks_key_r       <= {KEY_SIZE{1'b0}};
            ks_round_ctr_r <= {BLOCK_SIZE{1'b0}};
            ks_start_r     <= 1'b0;
            busy_r         <= 1'b0;
            keys_valid_r   <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ks_done_q_r <= ks.ks_done;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        ks_key_r     <= key_in;
                        keys_valid_r <= 1'b0;
                        error_r      <= 1'b0;
                        busy_r       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    iter_r         <= {ADDR_W{1'b0}};
                    ks_round_ctr_r <= {BLOCK_SIZE{1'b0}};
                    ks_start_r     <= 1'b1;
                end
                ST_ISSUE: begin
                    ks_start_r <= 1'b0;
                    wd_cnt_r   <= {WD_W{1'b0}};
                end
                ST_WAIT: begin
                    if (ks_event_s) begin
                        wd_cnt_r <= wd_cnt_r;
                    end else if (wd_expired_s) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
                end
                ST_STORE: begin
                    ks_key_r <= ks.ks_out_key;
                    if (last_iter_s) begin
                        busy_r       <= 1'b0;
                        keys_valid_r <= 1'b1;
                    end else begin
                        iter_r         <= iter_inc_s;
                        ks_round_ctr_r <= {{CTR_PAD{1'b0}}, iter_inc_s};
                        ks_start_r     <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    ks_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Round key storage write
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            key_buf_r[buf_waddr_s] <= buf_wdata_s;
        end
    end

    // Registered read port; reads zero until a full key set is present
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {BLOCK_SIZE{1'b0}};
        end else if (keys_valid_r && rd_in_range_s) begin
            rd_data_r <= key_buf_r[rd_addr];
        end else begin
            rd_data_r <= {BLOCK_SIZE{1'b0}};
        end
    end

endmodule

// File: tb/tb_speck_round_key_sequencer.sv
// Self-checking bench for speck_round_key_sequencer. A behavioural key
// schedule model answers each ks_start after a programmable latency with
// {high word, low word + 1 + round counter}. Expected round keys therefore
// follow the closed form base + i*(i+1)/2, and busy lasts 1 + 31*(2+L) cycles.
module tb_speck_round_key_sequencer;

    localparam int KS = 128;
    localparam int BS = 64;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic [KS-1:0] key_in;
    logic          start;
    logic          busy;
    logic          keys_valid;
    logic          error;
    logic [AW-1:0] rd_addr;
    logic [BS-1:0] rd_data;

    speck_round_key_sequencer_if #(.KEY_SIZE(KS), .BLOCK_SIZE(BS)) ks_if ();

    speck_round_key_sequencer #(
        .KEY_SIZE(KS), .BLOCK_SIZE(BS), .ROUNDS(NR), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .start(start),
        .busy(busy), .keys_valid(keys_valid), .error(error),
        .rd_addr(rd_addr), .rd_data(rd_data), .ks(ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Key schedule model controls
    int lat        = 6;  // WAIT cycles until the done rising edge is seen
    int hold_extra = 0;  // cycles ks_done stays high after ks_start
    bit never_done = 1'b0;
    int ks_cnt;
    int hold_cnt;
    bit pend;

    // Behavioural key schedule block
    always @(posedge clk) begin
        if (rst) begin
            ks_if.ks_done <= 1'b0;
            ks_if.ks_out_key <= '0;
            pend     <= 1'b0;
            ks_cnt   <= 0;
            hold_cnt <= 0;
        end else if (ks_if.ks_start) begin
            pend     <= 1'b1;
            ks_cnt   <= 1;
            hold_cnt <= hold_extra;
            if (hold_extra == 0) ks_if.ks_done <= 1'b0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt <= hold_cnt - 1;
                if (hold_cnt == 1) ks_if.ks_done <= 1'b0;
            end
            if (pend) begin
                if (ks_cnt == lat - 1) begin
                    pend <= 1'b0;
                    if (!never_done) begin
                        ks_if.ks_done    <= 1'b1;
                        ks_if.ks_out_key <= {ks_if.ks_key[127:64],
                                             ks_if.ks_key[63:0] + 64'd1 + ks_if.ks_round_ctr};
                    end
                end else begin
                    ks_cnt <= ks_cnt + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_key(input logic [63:0] base, input int i);
        return base + 64'(i * (i + 1) / 2);
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic read_check(input int addr, input logic [63:0] exp, input string tag);
        @(negedge clk);
        rd_addr = AW'(addr);
        @(negedge clk);
        check_eq(tag, {64'd0, rd_data}, {64'd0, exp});
    endtask

    task automatic read_all(input logic [63:0] base, input string tag);
        for (int i = 0; i < NR; i++) read_check(i, exp_key(base, i), tag);
    endtask

    // Start an expansion and count busy cycles. Optionally pulse start or reset mid-run.
    task automatic run_expansion(input logic [127:0] key, input int exp_busy,
                                 input int inj_start_at, input int rst_at);
        int  cnt;
        bit  stop;
        cnt  = 0;
        stop = 1'b0;
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        while (busy && cnt < 3000 && !stop) begin
            cnt++;
            if (cnt == 1) begin
                check_eq("kv_low_after_start", {127'd0, keys_valid}, 128'd0);
                check_eq("err_clr_on_start", {127'd0, error}, 128'd0);
            end
            if (cnt == 2) check_eq("rd_zero_while_busy", {64'd0, rd_data}, 128'd0);
            start  = (cnt == inj_start_at);
            key_in = rand_key();
            if (cnt == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_eq("rst_busy", {127'd0, busy}, 128'd0);
                check_eq("rst_kv", {127'd0, keys_valid}, 128'd0);
                check_eq("rst_ks_start", {127'd0, ks_if.ks_start}, 128'd0);
                rst  = 1'b0;
                stop = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!stop) check_eq("busy_len", 128'(cnt), 128'(exp_busy));
    endtask

    initial begin
        logic [127:0] k;
        rst = 1'b1; start = 1'b0; key_in = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy0", {127'd0, busy}, 128'd0);
        check_eq("rst_kv0", {127'd0, keys_valid}, 128'd0);
        check_eq("rst_err0", {127'd0, error}, 128'd0);
        check_eq("rst_ks_start0", {127'd0, ks_if.ks_start}, 128'd0);
        check_eq("rst_rd0", {64'd0, rd_data}, 128'd0);
        check_eq("rst_ks_key0", ks_if.ks_key, 128'd0);
        check_eq("rst_ctr0", {64'd0, ks_if.ks_round_ctr}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic expansion of a zero key
        run_expansion(128'd0, 1 + 31 * 8, -1, -1);
        check_eq("done_kv", {127'd0, keys_valid}, 128'd1);
        check_eq("done_err", {127'd0, error}, 128'd0);
        check_eq("final_ks_key", ks_if.ks_key, {64'd0, exp_key(64'd0, 31)});
        read_check(0, 64'h0, "rd0");
        read_check(1, 64'h1, "rd1");
        read_check(2, 64'h3, "rd2");
        read_check(3, 64'h6, "rd3");
        read_check(31, 64'h1F0, "rd31");

        // Start pulse during busy is ignored
        run_expansion(128'd0, 249, 50, -1);
        check_eq("ign_start_err", {127'd0, error}, 128'd0);
        check_eq("ign_start_kv", {127'd0, keys_valid}, 128'd1);
        read_all(64'd0, "ign_start_key");

        // Restart from DONE with a new low word
        run_expansion({64'd0, 64'h100}, 249, -1, -1);
        read_check(1, 64'h101, "restart_rd1");
        read_check(31, 64'h2F0, "restart_rd31");

        // Watchdog timeout
        never_done = 1'b1;
        run_expansion(rand_key(), 2 + TO, -1, -1);
        check_eq("to_err", {127'd0, error}, 128'd1);
        check_eq("to_busy", {127'd0, busy}, 128'd0);
        check_eq("to_kv", {127'd0, keys_valid}, 128'd0);
        read_check(5, 64'h0, "to_rd");
        never_done = 1'b0;
        run_expansion(128'd0, 249, -1, -1);
        check_eq("to_recover_err", {127'd0, error}, 128'd0);
        check_eq("to_recover_kv", {127'd0, keys_valid}, 128'd1);

        // Reset in the middle of an expansion, then a clean rerun
        run_expansion(128'd0, -1, -1, 100);
        run_expansion(128'd0, 249, -1, -1);
        read_all(64'd0, "post_rst_key");

        // ks_done held high across the start of each iteration
        hold_extra = 2;
        run_expansion(128'd0, 249, -1, -1);
        read_all(64'd0, "hold_key");
        hold_extra = 0;

        // Randomized keys and latencies
        for (int r = 0; r < 6; r++) begin
            lat        = int'($urandom_range(2, 12));
            hold_extra = int'($urandom_range(0, lat - 2));
            k          = rand_key();
            run_expansion(k, 1 + 31 * (2 + lat), -1, -1);
            check_eq("rnd_kv", {127'd0, keys_valid}, 128'd1);
            check_eq("rnd_ks_key", ks_if.ks_key, {k[127:64], exp_key(k[63:0], 31)});
            for (int j = 0; j < 8; j++) begin
                int a;
                a = int'($urandom_range(0, NR - 1));
                read_check(a, exp_key(k[63:0], a), "rnd_rd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
